// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the shared-FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int unsigned DEFAULT_NUM_REQ    = 4;
    localparam int unsigned DEFAULT_DATA_WIDTH = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the search starts one past rr_ptr and wraps.
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEFAULT_NUM_REQ,
    parameter int GID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [GID_WIDTH-1:0] rr_ptr,
    output logic [GID_WIDTH-1:0] winner,
    output logic                 any_req
);

    logic                 found;
    logic [GID_WIDTH-1:0] cand;

    always_comb begin
        winner  = '0;
        any_req = |req;
        found   = 1'b0;
        cand    = '0;
        for (int unsigned k = 1; k <= int'(NUM_REQ); k++) begin
            cand = GID_WIDTH'((int'(rr_ptr) + k) % int'(NUM_REQ));
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-granular arbiter: grants one requester whole-packet access to a shared FIFO write port.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEFAULT_NUM_REQ,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int GID_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    input  logic                          fifo_full,
    output logic [GID_WIDTH-1:0]          grant_id,
    output logic                          busy
);

    arb_state_e           state_q, state_d;
    logic [GID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [GID_WIDTH-1:0] grant_id_q, grant_id_d;

    logic [GID_WIDTH-1:0]  winner;
    logic                  any_req;
    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .GID_WIDTH (GID_WIDTH)
    ) u_rr (
        .req     (req_valid),
        .rr_ptr  (rr_ptr_q),
        .winner  (winner),
        .any_req (any_req)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= GID_WIDTH'(NUM_REQ - 1);
            grant_id_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
        end
    end

    // Outputs are forced idle while rst is high so the reset cycle itself is quiet.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        req_ready  = '0;
        fifo_wr    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_id_d = winner;
                    state_d    = LOCKED;
                end
            end
            LOCKED: begin
                req_ready[grant_id_q] = ~fifo_full & ~rst;
                fifo_wr               = req_valid[grant_id_q] & ~fifo_full & ~rst;
                if (fifo_wr && req_last[grant_id_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = grant_id_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fifo_wr_data = rst ? data_arr[0] : data_arr[grant_id_q];
    assign grant_id     = grant_id_q;
    assign busy         = (state_q == LOCKED) & ~rst;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench: packet-level requester model predicts grants and the FIFO word stream.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int GW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            fifo_wr;
    logic [DW-1:0]   fifo_wr_data;
    logic            fifo_full;
    logic [GW-1:0]   grant_id;
    logic            busy;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .GID_WIDTH  (GW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .fifo_wr      (fifo_wr),
        .fifo_wr_data (fifo_wr_data),
        .fifo_full    (fifo_full),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } word_t;

    word_t         src_q [N][$];
    logic [DW-1:0] sb_q[$];
    int            seq = 0;

    // Reference model: who owns the port and where the next search starts.
    bit m_locked = 0;
    int m_owner  = 0;
    int m_ptr    = N - 1;

    bit            started = 0;
    bit            e_chk_grant;
    logic [N-1:0]  e_ready;
    bit            e_wr, e_busy;
    logic [DW-1:0] e_data;
    int            e_grant;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic refill(input int maxlen);
        for (int i = 0; i < N; i++) begin
            while (src_q[i].size() < 2) begin
                int len = $urandom_range(1, maxlen);
                for (int w = 0; w < len; w++) begin
                    word_t x;
                    x.data = {i[7:0], seq[23:0]};
                    x.last = (w == len - 1);
                    seq++;
                    src_q[i].push_back(x);
                end
            end
        end
    endtask

    task automatic cycle(input int p_valid, input int p_full, input int p_rst, input int maxlen);
        @(posedge clk);
        #1;
        refill(maxlen);
        rst       = ($urandom_range(0, 999) < p_rst);
        fifo_full = ($urandom_range(0, 99) < p_full);
        for (int i = 0; i < N; i++) begin
            req_valid[i]           = ($urandom_range(0, 99) < p_valid);
            req_data[i*DW +: DW]   = src_q[i][0].data;
            req_last[i]            = src_q[i][0].last;
        end
        #1;
        if (rst) begin
            e_chk_grant = 0;
            e_ready     = '0;
            e_wr        = 0;
            e_busy      = 0;
            e_data      = src_q[0][0].data;
            m_locked    = 0;
            m_ptr       = N - 1;
            m_owner     = 0;
        end else if (!m_locked) begin
            e_chk_grant = 1;
            e_grant     = m_owner;
            e_ready     = '0;
            e_wr        = 0;
            e_busy      = 0;
            e_data      = src_q[m_owner][0].data;
            for (int k = 1; k <= N; k++) begin
                int c = (m_ptr + k) % N;
                if (!m_locked && req_valid[c]) begin
                    m_owner  = c;
                    m_locked = 1;
                end
            end
        end else begin
            e_chk_grant = 1;
            e_grant     = m_owner;
            e_busy      = 1;
            e_ready     = fifo_full ? '0 : N'(1 << m_owner);
            e_wr        = req_valid[m_owner] && !fifo_full;
            e_data      = src_q[m_owner][0].data;
            if (e_wr) begin
                word_t x = src_q[m_owner].pop_front();
                sb_q.push_back(x.data);
                if (x.last) begin
                    m_ptr    = m_owner;
                    m_locked = 0;
                end
            end
        end
        started = 1;
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("busy", 64'(busy), 64'(e_busy));
            check("fifo_wr", 64'(fifo_wr), 64'(e_wr));
            check("req_ready", 64'(req_ready), 64'(e_ready));
            check("fifo_wr_data", 64'(fifo_wr_data), 64'(e_data));
            if (e_chk_grant)
                check("grant_id", 64'(grant_id), 64'(e_grant));
            if (fifo_wr === 1'b1) begin
                if (sb_q.size() == 0)
                    check("sb_unexpected_write", 64'(fifo_wr_data), 64'hDEAD_BEEF);
                else
                    check("sb_word", 64'(fifo_wr_data), 64'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        repeat (3) cycle(0, 0, 1000, 1);
        // All requesters valid with single-word packets: strict 0,1,2,3,0 rotation.
        repeat (40) cycle(100, 0, 0, 1);
        repeat (3000) cycle(70, 25, 3, 4);
        repeat (800) cycle(25, 10, 2, 5);
        repeat (400) cycle(100, 50, 0, 3);
        @(posedge clk);
        #1;
        started = 0;
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
